// File: rtl/conv_pkg.sv
// conv_pkg: width helpers, saturation and default-configuration array types for the KxK convolution engine
package conv_pkg;
  localparam int CONV_DW = 5;
  localparam int CONV_K = 3;
  function automatic int conv_kxk_acc_width(input int dw, input int k);
    return 2 * dw + $clog2(k * k);
  endfunction
  function automatic int conv_row_width(input int dw, input int k);
    return 2 * dw + $clog2(k);
  endfunction
  localparam int CONV_ACC = conv_kxk_acc_width(CONV_DW, CONV_K);
  typedef logic [CONV_K-1:0][CONV_K-1:0][CONV_DW-1:0] conv_win_t;
  typedef logic [CONV_K-1:0][CONV_K-1:0][CONV_DW-1:0] conv_kernel_t;
  function automatic logic signed [63:0] conv_sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/conv_row_adder.sv
// conv_row_adder: combinational sum of N sign-extended terms
module conv_row_adder #(
  parameter int N = 3,
  parameter int IW = 10,
  parameter int OW = 12
) (
  input  logic [N-1:0][IW-1:0] terms,
  output logic [OW-1:0]        sum
);
  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++) sum = sum + OW'($signed(terms[i]));
  end
endmodule

// File: rtl/conv_kxk_pipe.sv
// conv_kxk_pipe: KxK signed window x kernel engine, products -> row sums -> total -> saturate/ReLU output
module conv_kxk_pipe
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 5,
  parameter int KSIZE = 3,
  parameter int ACC_WIDTH = conv_kxk_acc_width(DATA_WIDTH, KSIZE)
) (
  input  logic                                        i_clk,
  input  logic                                        i_rst,
  input  logic                                        i_valid,
  output logic                                        o_ready,
  input  logic [KSIZE-1:0][KSIZE-1:0][DATA_WIDTH-1:0] i_data,
  input  logic                                        i_kernel_ld,
  input  logic [KSIZE-1:0][KSIZE-1:0][DATA_WIDTH-1:0] i_kernel,
  input  logic [ACC_WIDTH-1:0]                        i_bias,
  input  logic                                        i_relu_en,
  output logic                                        o_valid,
  input  logic                                        i_ready,
  output logic [ACC_WIDTH-1:0]                        o_result,
  output logic                                        o_busy
);
  localparam int PW = 2 * DATA_WIDTH;
  localparam int RW = conv_row_width(DATA_WIDTH, KSIZE);
  localparam int TW = ACC_WIDTH + 1;
  logic [KSIZE-1:0][KSIZE-1:0][DATA_WIDTH-1:0] kernel;
  logic [KSIZE-1:0][KSIZE-1:0][PW-1:0] prod, s1_p;
  logic [KSIZE-1:0][RW-1:0] row_sum, s2_row;
  logic [TW-1:0] row_total, total, s3_total;
  logic [ACC_WIDTH-1:0] s1_bias, s2_bias, sat, res;
  logic s1_v, s2_v, s3_v, s1_relu, s2_relu, s3_relu, adv;
  assign adv = ~o_valid | i_ready;
  assign o_ready = adv;
  assign o_busy = s1_v | s2_v | s3_v;
  // operands widened first so the product is exact at 2*DATA_WIDTH
  always_comb begin
    prod = '0;
    for (int r = 0; r < KSIZE; r++)
      for (int c = 0; c < KSIZE; c++)
        prod[r][c] = PW'($signed(i_data[r][c])) * PW'($signed(kernel[r][c]));
  end
  for (genvar r = 0; r < KSIZE; r++) begin : g_row
    conv_row_adder #(.N(KSIZE), .IW(PW), .OW(RW)) u_row (.terms(s1_p[r]), .sum(row_sum[r]));
  end
  conv_row_adder #(.N(KSIZE), .IW(RW), .OW(TW)) u_total (.terms(s2_row), .sum(row_total));
  assign total = row_total + TW'($signed(s2_bias));
  assign sat = ACC_WIDTH'(conv_sat(64'($signed(s3_total)), ACC_WIDTH));
  assign res = (s3_relu && sat[ACC_WIDTH-1]) ? '0 : sat;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      kernel <= '0;
      s1_v <= 1'b0;
      s1_p <= '0;
      s1_bias <= '0;
      s1_relu <= 1'b0;
      s2_v <= 1'b0;
      s2_row <= '0;
      s2_bias <= '0;
      s2_relu <= 1'b0;
      s3_v <= 1'b0;
      s3_total <= '0;
      s3_relu <= 1'b0;
      o_valid <= 1'b0;
      o_result <= '0;
    end else begin
      if (i_kernel_ld) kernel <= i_kernel;
      if (adv) begin
        s1_v <= i_valid;
        s1_p <= prod;
        s1_bias <= i_bias;
        s1_relu <= i_relu_en;
        s2_v <= s1_v;
        s2_row <= row_sum;
        s2_bias <= s1_bias;
        s2_relu <= s1_relu;
        s3_v <= s2_v;
        s3_total <= total;
        s3_relu <= s2_relu;
        o_valid <= s3_v;
        if (s3_v) o_result <= res;
      end
    end
endmodule
